// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM receive front end: sample width, framer
// FSM encoding, the buffered sample record and the offset-binary converter.
package ofdm_pkg;

    localparam int SAMPLE_W = 10;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_CONVERT = 2'd2;
    localparam logic [1:0] S_PUSH    = 2'd3;

    typedef struct packed {
        logic                last;
        logic [SAMPLE_W-1:0] data;
    } sample_t;

    // Offset binary to two's complement is just an MSB flip.
    function automatic logic [SAMPLE_W-1:0] offset_to_signed(input logic [SAMPLE_W-1:0] raw);
        return {~raw[SAMPLE_W-1], raw[SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word fall-through FIFO. A push into a full FIFO is still taken when
// a pop happens in the same cycle; otherwise it is ignored.
module sample_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Zero while empty so the output port has a defined reset value.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/adc_sample_framer.sv
// Paces the MCP3002 controller at SAMPLE_RATE, converts each result to signed
// and streams it out through a FIFO with an end-of-frame marker.
module adc_sample_framer
    import ofdm_pkg::*;
#(
    parameter int CLK_FREQ    = 27_000_000,
    parameter int SAMPLE_RATE = 45_000,
    parameter int FRAME_LEN   = 64,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    output logic                adc_enable,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_available,
    output logic                adc_clear_available,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_last,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                fifo_overflow,
    output logic                adc_overrun,
    input  logic                status_clear
);

    localparam int TICK = CLK_FREQ / SAMPLE_RATE;
    localparam int CW   = $clog2(TICK);
    localparam int FW   = $clog2(FRAME_LEN);

    logic [CW-1:0] count_q, count_d;
    logic          tick;
    logic [1:0]    state_q, state_d;
    logic [FW-1:0] frame_idx_q, frame_idx_d;
    sample_t       sample_q, sample_d;
    logic          adc_enable_q, adc_enable_d;
    logic          adc_clear_q, adc_clear_d;
    logic          overflow_q, overflow_d;
    logic          overrun_q, overrun_d;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty, write_ok;
    sample_t       fifo_rdata;

    always_comb begin
        count_d = '0;
        if (enable) count_d = (count_q == CW'(TICK - 1)) ? '0 : count_q + CW'(1);
    end

    assign tick     = enable && (count_q == '0);
    assign fifo_pop = !fifo_empty && sample_ready;
    assign write_ok = !fifo_full || fifo_pop;

    // CONVERT is only entered the cycle after the start/clear pulse, by which
    // time the controller has dropped any stale available flag.
    always_comb begin
        state_d      = state_q;
        frame_idx_d  = frame_idx_q;
        sample_d     = sample_q;
        adc_enable_d = 1'b0;
        adc_clear_d  = 1'b0;
        fifo_push    = 1'b0;
        overflow_d   = overflow_q && !status_clear;
        overrun_d    = overrun_q && !status_clear;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    frame_idx_d = '0;
                    state_d     = S_WAIT;
                    if (tick) begin
                        adc_enable_d = 1'b1;
                        adc_clear_d  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (adc_enable_q) begin
                    state_d = S_CONVERT;
                end else if (tick) begin
                    adc_enable_d = 1'b1;
                    adc_clear_d  = 1'b1;
                end else if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            S_CONVERT: begin
                if (tick) overrun_d = 1'b1;
                if (adc_available) begin
                    sample_d.data = offset_to_signed(adc_data);
                    sample_d.last = (frame_idx_q == FW'(FRAME_LEN - 1));
                    adc_clear_d   = 1'b1;
                    state_d       = S_PUSH;
                end
            end
            S_PUSH: begin
                // A tick here only happens if the conversion ran a full period.
                if (tick) overrun_d = 1'b1;
                fifo_push = 1'b1;
                if (write_ok) begin
                    frame_idx_d = (frame_idx_q == FW'(FRAME_LEN - 1)) ? '0 : frame_idx_q + FW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
                state_d = enable ? S_WAIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            state_q      <= S_IDLE;
            frame_idx_q  <= '0;
            sample_q     <= '0;
            adc_enable_q <= 1'b0;
            adc_clear_q  <= 1'b0;
            overflow_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            count_q      <= count_d;
            state_q      <= state_d;
            frame_idx_q  <= frame_idx_d;
            sample_q     <= sample_d;
            adc_enable_q <= adc_enable_d;
            adc_clear_q  <= adc_clear_d;
            overflow_q   <= overflow_d;
            overrun_q    <= overrun_d;
        end
    end

    sample_fifo #(
        .WIDTH ($bits(sample_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (sample_q),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign adc_enable          = adc_enable_q;
    assign adc_clear_available = adc_clear_q;
    assign sample_data         = fifo_rdata.data;
    assign sample_last         = fifo_rdata.last;
    assign sample_valid        = !fifo_empty;
    assign fifo_overflow       = overflow_q;
    assign adc_overrun         = overrun_q;

endmodule

// File: tb/tb_adc_sample_framer.sv
// Scoreboard bench for adc_sample_framer with a behavioural MCP3002 model.
// The clock ratio is scaled down to a 60-cycle tick so every scenario fits a short run.
module tb_adc_sample_framer;

    localparam int CLK_FREQ    = 2_700_000;
    localparam int SAMPLE_RATE = 45_000;
    localparam int TICK        = 60;
    localparam int FRAME_LEN   = 64;
    localparam int FIFO_DEPTH  = 16;
    localparam int CONV_DELAY  = 20;
    localparam int SLOW_DELAY  = 70;

    typedef struct {
        logic [9:0] data;
        logic       last;
        int         tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       sampleReady = 1'b0;
    logic       statusClear = 1'b0;
    logic       adcEnable, adcClearAvailable, sampleValid, sampleLast;
    logic       fifoOverflow, adcOverrun;
    logic [9:0] sampleData;
    logic       adcAvailable = 1'b1;
    logic [9:0] adcData = 10'h3FF;

    int         testsRun = 0;
    int         testsFailed = 0;
    int         cycle = 0;
    int         pulseCount = 0;
    int         lastPulseCycle = 0;
    int         prevPulseCycle = 0;
    int         popCount = 0;
    int         convDone = 0;
    int         adcDelay = CONV_DELAY;
    int         convCnt = 0;
    logic       adcBusy = 1'b0;
    logic       validBeforePulse = 1'b0;
    logic [9:0] adcValQ[$];
    exp_t       expQ[$];

    adc_sample_framer #(
        .CLK_FREQ    (CLK_FREQ),
        .SAMPLE_RATE (SAMPLE_RATE),
        .FRAME_LEN   (FRAME_LEN),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .adc_enable          (adcEnable),
        .adc_data            (adcData),
        .adc_available       (adcAvailable),
        .adc_clear_available (adcClearAvailable),
        .sample_data         (sampleData),
        .sample_last         (sampleLast),
        .sample_valid        (sampleValid),
        .sample_ready        (sampleReady),
        .fifo_overflow       (fifoOverflow),
        .adc_overrun         (adcOverrun),
        .status_clear        (statusClear)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // ADC model: a start pulse begins a conversion of adcDelay cycles; the clear pulse drops the flag.
    always @(posedge clk) begin
        if (adcClearAvailable) adcAvailable <= 1'b0;
        if (adcEnable) begin
            adcBusy <= 1'b1;
            convCnt <= adcDelay;
        end else if (adcBusy) begin
            convCnt <= convCnt - 1;
            if (convCnt == 1) begin
                adcBusy      <= 1'b0;
                adcAvailable <= 1'b1;
                convDone     <= convDone + 1;
                if (adcValQ.size() > 0) adcData <= adcValQ.pop_front();
                else                    adcData <= 10'h155;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic rdy);
        enable      = en;
        sampleReady = rdy;
    endtask

    task automatic pushExpected(input logic [9:0] data, input logic last, input int tag);
        exp_t e;
        e.data = data;
        e.last = last;
        e.tag  = tag;
        expQ.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitPops(input int target, input int budget, input string name);
        int n = 0;
        while (popCount < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (popCount < target) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s timeout: got %0d pops, required %0d", name, popCount, target);
        end
    endtask

    task automatic waitPulses(input int target, input int budget, input string name);
        int n = 0;
        while (pulseCount < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (pulseCount < target) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s timeout: got %0d pulses, required %0d", name, pulseCount, target);
        end
    endtask

    task automatic waitConv(input int target, input int budget, input string name);
        int n = 0;
        while (convDone < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (convDone < target) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s timeout: got %0d conversions, required %0d", name, convDone, target);
        end
    endtask

    // Start pulses must always carry the clear pulse with them.
    initial forever begin
        @(negedge clk);
        if (adcEnable) begin
            checkOutput("clear_with_enable", 32'(adcClearAvailable), 32'd1);
            pulseCount++;
            prevPulseCycle = lastPulseCycle;
            lastPulseCycle = cycle;
        end
        if (sampleValid && pulseCount == 0) validBeforePulse = 1'b1;
    end

    // Scoreboard monitor: every handshake pops one expected sample.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && sampleValid && sampleReady) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_sample: got data=%h last=%b, required no sample", sampleData, sampleLast);
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("sample%0d_data", e.tag), 32'(sampleData), 32'(e.data));
                checkOutput($sformatf("sample%0d_last", e.tag), 32'(sampleLast), 32'(e.last));
            end
            popCount++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, required finish before cycle 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int pulseBase;
        logic [9:0] v;
        logic idleActivity;

        // Reset with the ADC holding a stale result.
        applyStimulus(1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_adc_enable", 32'(adcEnable), 32'd0);
        checkOutput("reset_clear", 32'(adcClearAvailable), 32'd0);
        checkOutput("reset_valid", 32'(sampleValid), 32'd0);
        checkOutput("reset_data", 32'(sampleData), 32'd0);
        checkOutput("reset_last", 32'(sampleLast), 32'd0);
        checkOutput("reset_overflow", 32'(fifoOverflow), 32'd0);
        checkOutput("reset_overrun", 32'(adcOverrun), 32'd0);
        rst = 1'b0;
        idleActivity = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            idleActivity = idleActivity | sampleValid | adcEnable;
        end
        checkOutput("idle_no_activity", 32'(idleActivity), 32'd0);

        // Offset-binary conversion and tick spacing.
        adcValQ.push_back(10'h000);
        adcValQ.push_back(10'h200);
        adcValQ.push_back(10'h3FF);
        pushExpected(10'h200, 1'b0, 0);
        pushExpected(10'h000, 1'b0, 1);
        pushExpected(10'h1FF, 1'b0, 2);
        base = popCount;
        applyStimulus(1'b1, 1'b1);
        waitPulses(1, TICK, "first_pulse");
        checkOutput("valid_before_first_pulse", 32'(validBeforePulse), 32'd0);
        waitPulses(2, 2 * TICK, "second_pulse");
        checkOutput("pulse_spacing_1", 32'(lastPulseCycle - prevPulseCycle), 32'(TICK));
        waitPulses(3, 2 * TICK, "third_pulse");
        checkOutput("pulse_spacing_2", 32'(lastPulseCycle - prevPulseCycle), 32'(TICK));
        waitPops(base + 3, 2 * TICK, "conversion_pops");
        applyStimulus(1'b0, 1'b1);
        waitCycles(10);

        // Frame marker over 130 samples, then a fresh frame after re-enable.
        for (int i = 0; i < 130; i++) begin
            v = 10'((i * 37 + 5) & 10'h3FF);
            adcValQ.push_back(v);
            pushExpected(v ^ 10'h200, (i % 64) == 63, 100 + i);
        end
        base = popCount;
        applyStimulus(1'b1, 1'b1);
        waitPops(base + 130, 130 * TICK + 200, "frame_pops");
        applyStimulus(1'b0, 1'b1);
        waitCycles(10);
        for (int i = 0; i < 64; i++) begin
            v = 10'((i * 11 + 3) & 10'h3FF);
            adcValQ.push_back(v);
            pushExpected(v ^ 10'h200, i == 63, 300 + i);
        end
        base = popCount;
        applyStimulus(1'b1, 1'b1);
        waitPops(base + 64, 64 * TICK + 200, "reenable_pops");
        applyStimulus(1'b0, 1'b1);
        waitCycles(10);

        // Overflow: 18 conversions into a 16-deep FIFO with no reader.
        for (int i = 0; i < 18; i++) begin
            v = 10'(10'h100 + i);
            adcValQ.push_back(v);
            if (i < 16) pushExpected(v ^ 10'h200, 1'b0, 500 + i);
        end
        base = convDone;
        applyStimulus(1'b1, 1'b0);
        waitConv(base + 18, 18 * TICK + 200, "overflow_conversions");
        waitCycles(3);
        applyStimulus(1'b0, 1'b0);
        waitCycles(5);
        checkOutput("overflow_flag", 32'(fifoOverflow), 32'd1);
        checkOutput("overflow_valid_held", 32'(sampleValid), 32'd1);
        checkOutput("overflow_head_data", 32'(sampleData), 32'h300);
        base = popCount;
        applyStimulus(1'b0, 1'b1);
        waitPops(base + 16, 40, "overflow_drain");
        waitCycles(2);
        checkOutput("fifo_drained", 32'(sampleValid), 32'd0);
        checkOutput("overflow_pops", 32'(popCount - base), 32'd16);
        statusClear = 1'b1;
        waitCycles(1);
        statusClear = 1'b0;
        checkOutput("overflow_cleared", 32'(fifoOverflow), 32'd0);

        // Overrun: a 70-cycle conversion swallows one tick.
        checkOutput("no_overrun_default", 32'(adcOverrun), 32'd0);
        adcDelay = SLOW_DELAY;
        adcValQ.push_back(10'h050);
        adcValQ.push_back(10'h060);
        pushExpected(10'h250, 1'b0, 700);
        pushExpected(10'h260, 1'b0, 701);
        pulseBase = pulseCount;
        base = popCount;
        applyStimulus(1'b1, 1'b1);
        waitPulses(pulseBase + 1, TICK, "overrun_first_pulse");
        adcDelay = CONV_DELAY;
        waitPulses(pulseBase + 2, 3 * TICK, "overrun_second_pulse");
        checkOutput("overrun_spacing", 32'(lastPulseCycle - prevPulseCycle), 32'(2 * TICK));
        checkOutput("overrun_flag", 32'(adcOverrun), 32'd1);
        waitPops(base + 2, 2 * TICK, "overrun_pops");
        applyStimulus(1'b0, 1'b1);
        waitCycles(10);

        // Disable mid-conversion: sample still arrives, no further starts.
        adcValQ.push_back(10'h3C0);
        pushExpected(10'h1C0, 1'b0, 800);
        pulseBase = pulseCount;
        base = popCount;
        applyStimulus(1'b1, 1'b1);
        waitPulses(pulseBase + 1, TICK, "disable_pulse");
        waitCycles(5);
        applyStimulus(1'b0, 1'b1);
        waitPops(base + 1, 2 * TICK, "disable_pop");
        waitCycles(3 * TICK);
        checkOutput("no_pulse_after_disable", 32'(pulseCount), 32'(pulseBase + 1));

        // Reset mid-conversion with a sample parked in the FIFO.
        adcValQ.push_back(10'h0AB);
        adcValQ.push_back(10'h0CD);
        pulseBase = pulseCount;
        base = convDone;
        applyStimulus(1'b1, 1'b0);
        waitConv(base + 1, 2 * TICK, "prereset_conversion");
        waitPulses(pulseBase + 2, 2 * TICK, "prereset_second_pulse");
        waitCycles(5);
        checkOutput("prereset_valid", 32'(sampleValid), 32'd1);
        checkOutput("prereset_data", 32'(sampleData), 32'h2AB);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        waitCycles(1);
        checkOutput("midconv_reset_adc_enable", 32'(adcEnable), 32'd0);
        checkOutput("midconv_reset_clear", 32'(adcClearAvailable), 32'd0);
        checkOutput("midconv_reset_valid", 32'(sampleValid), 32'd0);
        checkOutput("midconv_reset_data", 32'(sampleData), 32'd0);
        checkOutput("midconv_reset_last", 32'(sampleLast), 32'd0);
        checkOutput("midconv_reset_overflow", 32'(fifoOverflow), 32'd0);
        checkOutput("midconv_reset_overrun", 32'(adcOverrun), 32'd0);
        rst = 1'b0;
        waitCycles(TICK);
        checkOutput("post_reset_idle_valid", 32'(sampleValid), 32'd0);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
